instr_exec_unit: RTL and testbench

//  Execute stage downstream of the instruction register file. On start, walks
//  `count` entries from `first_index`, drives read_index, and captures the

---
 rtl/instr_exec_unit.sv | 189 ++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// instr_exec_unit
//   Execute stage behind the instruction register file. A start request
//   latches a batch (first_index, count). For each entry the unit addresses the
//   register file via read_index, captures opcode/operands, evaluates the
//   instruction and presents the result on a valid/ready stream.
// Ports
//   clk, reset_en (async, active-low)
//   start, first_index, count       batch request, sampled only when idle
//   busy, done                      batch status (done is a 1-cycle pulse)
//   read_index, opcode, operand_a/b register-file read port (combinational data)
//   res_valid, res_ready            result stream handshake
//   res_index, res_opcode, result   result beat payload
//   div_by_zero, illegal_op         result beat flags
module instr_exec_unit #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int OP_W  = 32,
  parameter int RES_W = 2*OP_W
) (
  input  logic                    clk,
  input  logic                    reset_en,
  input  logic                    start,
  input  logic [IDX_W-1:0]        first_index,
  input  logic [IDX_W:0]          count,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        read_index,
  input  logic [3:0]              opcode,
  input  logic signed [OP_W-1:0]  operand_a,
  input  logic signed [OP_W-1:0]  operand_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [IDX_W-1:0]        res_index,
  output logic [3:0]              res_opcode,
  output logic signed [RES_W-1:0] result,
  output logic                    div_by_zero,
  output logic                    illegal_op
);
  localparam int CNT_W = $clog2(OP_W+1);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_DONE} state_t;
  state_t state, state_n;

  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   remaining;

  logic [3:0]              op_p0;
  logic signed [OP_W-1:0]  a_p0, b_p0;
  logic [OP_W-1:0]         quo_p1, rem_p1, dvs_p1;
  logic [CNT_W-1:0]        cnt_p1;

  // Magnitude of a signed operand; the most-negative value maps to 2^(OP_W-1),
  // which still fits in OP_W unsigned bits.
  function automatic logic [OP_W-1:0] mag(input logic signed [OP_W-1:0] v);
    return v[OP_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Re-apply a sign to an unsigned divider magnitude at full result width so
  // that most-negative / -1 yields +2^(OP_W-1) without wrapping.
  function automatic logic signed [RES_W-1:0] apply_sign(input logic [OP_W-1:0] m,
                                                         input logic neg);
    logic signed [RES_W-1:0] e;
    e = $signed({{(RES_W-OP_W){1'b0}}, m});
    return neg ? -e : e;
  endfunction

  logic is_div, div_run, exec_last, handshake;
  logic [OP_W:0] rem_sh, rem_sub;
  logic          rem_ge;

  assign is_div    = (op_p0 == OP_DIV) || (op_p0 == OP_MOD);
  assign div_run   = is_div && (b_p0 != '0);
  // Divide steps for OP_W cycles, then one extra cycle for the sign fix-up.
  assign exec_last = !div_run || (cnt_p1 == CNT_W'(OP_W));
  assign handshake = (state == S_OUT) && res_ready;

  assign rem_sh  = {rem_p1, quo_p1[OP_W-1]};
  assign rem_ge  = rem_sh >= {1'b0, dvs_p1};
  assign rem_sub = rem_sh - {1'b0, dvs_p1};

  assign read_index = idx;
  assign res_index  = idx;

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_n = (count == '0) ? S_DONE : S_FETCH;
      S_FETCH: begin
        busy    = 1'b1;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (exec_last) state_n = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_n = (remaining == (IDX_W+1)'(1)) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      state     <= S_IDLE;
      idx       <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        idx       <= first_index;
        remaining <= count;
      end else if (handshake) begin
        idx       <= (idx == IDX_W'(DEPTH-1)) ? '0 : idx + IDX_W'(1);
        remaining <= remaining - (IDX_W+1)'(1);
      end
    end
  end

  // ---- p0/p1: operand capture at end of FETCH, restoring divider in EXEC ----
  always_ff @(posedge clk) begin
    if (state == S_FETCH) begin
      op_p0  <= opcode;
      a_p0   <= operand_a;
      b_p0   <= operand_b;
      quo_p1 <= mag(operand_a);
      dvs_p1 <= mag(operand_b);
      rem_p1 <= '0;
      cnt_p1 <= '0;
    end else if (state == S_EXEC && !exec_last) begin
      rem_p1 <= rem_ge ? rem_sub[OP_W-1:0] : rem_sh[OP_W-1:0];
      quo_p1 <= {quo_p1[OP_W-2:0], rem_ge};
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  logic signed [RES_W-1:0] a_x, b_x, alu_res;
  assign a_x = {{(RES_W-OP_W){a_p0[OP_W-1]}}, a_p0};
  assign b_x = {{(RES_W-OP_W){b_p0[OP_W-1]}}, b_p0};

  always_comb begin
    alu_res = '0;
    case (op_p0)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = a_x;
      OP_PASSB: alu_res = b_x;
      OP_ADD:   alu_res = a_x + b_x;
      OP_SUB:   alu_res = a_x - b_x;
      OP_MULT:  alu_res = a_x * b_x;
      OP_DIV:   alu_res = div_run ? apply_sign(quo_p1, a_p0[OP_W-1] ^ b_p0[OP_W-1]) : '0;
      OP_MOD:   alu_res = div_run ? apply_sign(rem_p1, a_p0[OP_W-1]) : '0;
      default:  alu_res = '0;
    endcase
  end

  // ---- p2: result beat register, held through OUT until accepted ----
  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      res_opcode  <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (state == S_EXEC && exec_last) begin
      res_opcode  <= op_p0;
      result      <= alu_res;
      div_by_zero <= is_div && (b_p0 == '0);
      illegal_op  <= op_p0 > OP_MOD;
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
`timescale 1ns/1ps
module tb_instr_exec_unit;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  logic                    clk = 1'b0;
  logic                    reset_en = 1'b0;
  logic                    start = 1'b0;
  logic [IDX_W-1:0]        first_index = '0;
  logic [IDX_W:0]          count = '0;
  logic                    busy, done;
  logic [IDX_W-1:0]        read_index;
  logic [3:0]              opcode;
  logic signed [OP_W-1:0]  operand_a, operand_b;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic [IDX_W-1:0]        res_index;
  logic [3:0]              res_opcode;
  logic signed [RES_W-1:0] result;
  logic                    div_by_zero, illegal_op;

  // Instruction register file model
  logic [3:0]             mem_op [DEPTH];
  logic signed [OP_W-1:0] mem_a  [DEPTH];
  logic signed [OP_W-1:0] mem_b  [DEPTH];
  assign opcode    = mem_op[read_index];
  assign operand_a = mem_a[read_index];
  assign operand_b = mem_b[read_index];

  instr_exec_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset_en(reset_en), .start(start), .first_index(first_index),
    .count(count), .busy(busy), .done(done), .read_index(read_index),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
    .res_opcode(res_opcode), .result(result), .div_by_zero(div_by_zero),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     idx;
    int     op;
    longint res;
    bit     dbz;
    bit     ill;
  } beat_t;

  beat_t sb[$];
  int errors = 0, checks = 0, done_cnt = 0, beat_cnt = 0, exp_done = 0;
  bit rdy_auto = 1'b1, rdy_rand = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: instruction semantics in plain 64-bit signed arithmetic
  function automatic beat_t model(input int i);
    beat_t  e;
    longint a, b;
    a = longint'(mem_a[i]);
    b = longint'(mem_b[i]);
    e.idx = i; e.op = int'(mem_op[i]); e.res = 0; e.dbz = 1'b0; e.ill = 1'b0;
    case (e.op)
      0: e.res = 0;
      1: e.res = a;
      2: e.res = b;
      3: e.res = a + b;
      4: e.res = a - b;
      5: e.res = a * b;
      6: if (b == 0) e.dbz = 1'b1; else e.res = a / b;
      7: if (b == 0) e.dbz = 1'b1; else e.res = a % b;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Ready driver
  initial forever begin
    @(posedge clk); #1;
    if (rdy_auto) res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted beat, checks held beats
  logic [IDX_W-1:0]        h_idx, h_rd;
  logic [5:0]              h_opf;
  logic signed [RES_W-1:0] h_res;
  bit                      stalled = 1'b0;
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (reset_en && res_valid) begin
      if (stalled) begin
        check("hold_result", result, h_res);
        check("hold_res_index", res_index, h_idx);
        check("hold_read_index", read_index, h_rd);
        check("hold_opcode_flags", {res_opcode, div_by_zero, illegal_op}, h_opf);
      end
      if (res_ready) begin
        beat_cnt++;
        stalled = 1'b0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got index %0d result %0d, expected no beat",
                   res_index, result);
        end else begin
          e = sb.pop_front();
          check("beat_index", res_index, e.idx);
          check("beat_opcode", res_opcode, e.op);
          check("beat_result", result, e.res);
          check("beat_flags", {div_by_zero, illegal_op}, {e.dbz, e.ill});
        end
      end else begin
        stalled = 1'b1;
        h_res = result; h_idx = res_index; h_rd = read_index;
        h_opf = {res_opcode, div_by_zero, illegal_op};
      end
    end else begin
      stalled = 1'b0;
    end
    if (reset_en && done) begin
      done_cnt++;
      check("done_after_all_beats", sb.size(), 0);
    end
  end

  // Issue a batch; lat = cycles from start to first res_valid (or to done)
  task automatic launch(input int first, input int cnt, output int lat);
    for (int i = 0; i < cnt; i++) sb.push_back(model((first + i) % DEPTH));
    @(posedge clk); #1;
    first_index = IDX_W'(first);
    count       = (IDX_W+1)'(cnt);
    start       = 1'b1;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 1 && cnt > 0) check("busy_after_start", busy, 1);
      if (res_valid || done) begin lat = n; break; end
    end
    exp_done++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < exp_done && n < 4000) begin @(posedge clk); n++; end
    check("done_pulses", done_cnt, exp_done);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctrl"}, {busy, done, read_index, res_valid, res_index,
                            res_opcode, div_by_zero, illegal_op}, 0);
    check({name, "_result"}, result, 0);
  endtask

  initial begin
    int lat, base_b, base_d;
    for (int i = 0; i < DEPTH; i++) begin
      mem_op[i] = 4'd1; mem_a[i] = 1000 + i; mem_b[i] = -i;
    end

    // Power-on reset
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset_state");
    reset_en = 1'b1;

    // Basic batch
    mem_op[0] = 4'd3; mem_a[0] = 5;  mem_b[0] = 7;
    mem_op[1] = 4'd4; mem_a[1] = 3;  mem_b[1] = 10;
    mem_op[2] = 4'd5; mem_a[2] = -4; mem_b[2] = 6;
    launch(0, 3, lat);
    check("latency_single_cycle_op", lat, 3);
    wait_done();

    // Division family and illegal opcode
    mem_op[4] = 4'd6;  mem_a[4] = -7;            mem_b[4] = 2;
    mem_op[5] = 4'd7;  mem_a[5] = -7;            mem_b[5] = 2;
    mem_op[6] = 4'd6;  mem_a[6] = 9;             mem_b[6] = 0;
    mem_op[7] = 4'd6;  mem_a[7] = 32'sh80000000; mem_b[7] = -1;
    mem_op[8] = 4'd7;  mem_a[8] = 7;             mem_b[8] = -2;
    mem_op[9] = 4'd12; mem_a[9] = 55;            mem_b[9] = 3;
    launch(4, 6, lat);
    check("latency_div", lat, OP_W + 3);
    wait_done();
    launch(6, 1, lat);
    check("latency_div_by_zero", lat, 3);
    wait_done();

    // Index wrap
    launch(30, 4, lat);
    wait_done();

    // Back-pressure on beat 1, with a start request while busy
    for (int i = 10; i < 13; i++) begin
      mem_op[i] = 4'd3; mem_a[i] = $urandom; mem_b[i] = $urandom;
    end
    rdy_auto = 1'b0; res_ready = 1'b1;
    base_b = beat_cnt;
    launch(10, 3, lat);
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int n = 0; n < 20 && !res_valid; n++) begin @(posedge clk); #1; end
    check("stall_beat_present", res_valid, 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin first_index = 20; count = 5; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0; res_ready = 1'b1; rdy_auto = 1'b1;
    wait_done();
    repeat (20) @(posedge clk);
    check("start_while_busy_ignored_busy", busy, 0);
    check("start_while_busy_ignored_beats", beat_cnt - base_b, 3);

    // Empty batch
    base_b = beat_cnt;
    launch(3, 0, lat);
    check("count0_done_in_time", (lat >= 1 && lat <= 2), 1);
    wait_done();
    check("count0_no_beats", beat_cnt - base_b, 0);

    // Reset in the middle of a divide
    mem_op[15] = 4'd6; mem_a[15] = 1234567; mem_b[15] = -89;
    mem_op[16] = 4'd3; mem_a[16] = -2;      mem_b[16] = 9;
    @(posedge clk); #1;
    first_index = 15; count = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset_en = 1'b0;
    #1 check_outputs_zero("reset_mid_div");
    base_b = beat_cnt; base_d = done_cnt;
    repeat (3) @(posedge clk); #1;
    reset_en = 1'b1;
    repeat (40) @(posedge clk);
    check("reset_no_done", done_cnt - base_d, 0);
    check("reset_no_beat", beat_cnt - base_b, 0);
    launch(15, 2, lat);
    check("after_reset_latency_div", lat, OP_W + 3);
    wait_done();

    // Randomized batches with random back-pressure
    rdy_rand = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_op[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                                : 4'($urandom_range(0, 7));
        for (int s = 0; s < 2; s++) begin
          logic signed [OP_W-1:0] v;
          case ($urandom_range(0, 5))
            0: v = 0;
            1: v = -1;
            2: v = 32'sh80000000;
            3: v = $signed(32'($urandom_range(0, 20))) - 10;
            default: v = $urandom;
          endcase
          if (s == 0) mem_a[i] = v; else mem_b[i] = v;
        end
      end
      launch($urandom_range(0, DEPTH-1), $urandom_range(1, 10), lat);
      wait_done();
    end
    rdy_rand = 1'b0;

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
